// File: rtl/imem_boot_loader.sv
// Byte-stream program loader: assembles little-endian words from a framed,
// XOR-checksummed stream, writes them to instruction memory, then releases the CPU.
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_reset;
  logic                  r_done;
  logic                  r_error;
  logic [CW-1:0]         r_words;
  logic [15:0]           r_count;
  logic [1:0]            r_idx;
  logic [23:0]           r_word;
  logic [7:0]            r_csum;

  logic                  w_xfer;
  logic [15:0]           w_hdr_n;
  logic                  w_last;

  assign w_xfer  = in_valid && r_ready;
  assign w_hdr_n = {in_data, r_count[7:0]};
  // Word being completed now is the final one of the image.
  assign w_last  = ((16'(r_words) + 16'd1) == r_count);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_HDR0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_csum      <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_HDR0: begin
          r_ready <= 1'b1;
          if (w_xfer) begin
            r_count <= {8'h00, in_data};
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_xfer) begin
            r_count <= w_hdr_n;
            if (32'(w_hdr_n) > MAX_WORDS) begin
              r_ready <= 1'b0;
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end else if (w_hdr_n == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ in_data;
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= ADDR_WIDTH'(r_words);
              r_wdata <= {in_data, r_word};
              r_words <= r_words + CW'(1);
              if (w_last) r_state <= S_CSUM;
            end else begin
              r_word <= {in_data, r_word[23:8]};
            end
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_HDR0;
      endcase
    end
  end

  assign in_ready     = r_ready;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad frames, oversize and empty
// images, stalled stream, and reset in the middle of a frame.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] prog [5] = '{32'h00000013, 32'h00100093, 32'h00208113,
                            32'h00310193, 32'h0000006F};

  logic [7:0]  wa [16];
  logic [31:0] wd [16];
  logic [8:0]  wl [16];
  int          nw = 0;

  imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Log every instruction-memory write strobe.
  always @(negedge clk) begin
    if (imem_we && nw < 16) begin
      wa[nw] = imem_addr;
      wd[nw] = imem_wdata;
      wl[nw] = words_loaded;
      nw = nw + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready), 64'd0);
    chk("rst_imem_we",   64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata",     64'(imem_wdata), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_error",     64'(error), 64'd0);
    chk("rst_words",     64'(words_loaded), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    nw = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    budget   = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("handshake_ready", 64'(in_ready), 64'd1);
    if (in_ready) @(posedge clk);
  endtask

  task automatic send_frame(input logic [15:0] n, input int nwords,
                            input logic [7:0] csum, input bit gaps);
    logic [31:0] w;
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    for (int i = 0; i < nwords; i++) begin
      w = prog[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
    end
    send_byte(csum, gaps);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_writes(input int n);
    chk("write_count", 64'(nw), 64'(n));
    for (int i = 0; i < n && i < 16; i++) begin
      chk("write_addr",  64'(wa[i]), 64'(i));
      chk("write_data",  64'(wd[i]), 64'(prog[i]));
      chk("write_words", 64'(wl[i]), 64'(i + 1));
    end
  endtask

  task automatic chk_done_state(input logic [8:0] words);
    chk("done",         64'(done), 64'd1);
    chk("cpu_reset",    64'(cpu_reset), 64'd0);
    chk("error_clear",  64'(error), 64'd0);
    chk("ready_low",    64'(in_ready), 64'd0);
    chk("words_loaded", 64'(words_loaded), 64'(words));
  endtask

  task automatic chk_err_state(input logic [8:0] words);
    chk("error",        64'(error), 64'd1);
    chk("cpu_reset_hi", 64'(cpu_reset), 64'd1);
    chk("done_clear",   64'(done), 64'd0);
    chk("ready_low",    64'(in_ready), 64'd0);
    chk("words_loaded", 64'(words_loaded), 64'(words));
  endtask

  initial begin
    // Good 5-word image, streamed back to back.
    do_reset();
    send_frame(16'd5, 5, 8'hEE, 1'b0);
    chk_done_state(9'd5);
    chk_writes(5);

    // Same image, wrong checksum.
    do_reset();
    send_frame(16'd5, 5, 8'hEF, 1'b0);
    chk_err_state(9'd5);
    chk_writes(5);

    // Oversize header: 257 words.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_err_state(9'd0);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("oversize_no_write", 64'(nw), 64'd0);
    chk("oversize_sticky",   64'(error), 64'd1);

    // Empty image, good and bad checksum.
    do_reset();
    send_frame(16'd0, 0, 8'h00, 1'b0);
    chk_done_state(9'd0);
    chk("empty_no_write", 64'(nw), 64'd0);
    do_reset();
    send_frame(16'd0, 0, 8'h01, 1'b0);
    chk_err_state(9'd0);

    // Good image with random valid gaps, then stray bytes after completion.
    do_reset();
    send_frame(16'd5, 5, 8'hEE, 1'b1);
    chk_done_state(9'd5);
    chk_writes(5);
    in_data  = 8'hAA;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("post_done_no_write", 64'(nw), 64'd5);
    chk_done_state(9'd5);

    // Reset after two words, then a full reload.
    do_reset();
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("partial_writes", 64'(nw), 64'd2);
    chk("partial_words",  64'(words_loaded), 64'd2);
    chk("partial_done",   64'(done), 64'd0);
    do_reset();
    send_frame(16'd5, 5, 8'hEE, 1'b0);
    chk_done_state(9'd5);
    chk_writes(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader: the writer side of the CPU's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes those words into instruction memory from word address 0 upward.
- Holds the CPU in reset until a complete, checksum-verified image is loaded, then releases it so the CPU starts fetching at PC 0x00000000.

Parameters:
- ADDR_WIDTH, 8: width of the instruction-memory word address.
- MAX_WORDS, 256: largest accepted image in words; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising edge.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_WIDTH  word address of the write.
- imem_wdata  output  32  instruction word.
- cpu_reset  output  1  active-high reset to the CPU core.
- done  output  1  image loaded and checksum OK (sticky).
- error  output  1  frame rejected (sticky).
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Reset values (reset_n low, sampled at clk edge): in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0. Internal state goes to HDR0; byte index, checksum and count all clear.
- Reset has priority over all other activity, including mid-word and mid-frame. A partially loaded image is discarded; words already written are not scrubbed.
- Frame format: count_lo, count_hi (16-bit word count N, LE), then 4*N payload bytes (per word: byte0 = bits[7:0] … byte3 = bits[31:24]), then 1 checksum byte.
- Checksum = XOR of all payload bytes only; header bytes are excluded.
- States and transitions:
  - HDR0: accept count_lo -> HDR1.
  - HDR1: accept count_hi.
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CSUM (expected checksum 0x00).
    - Otherwise -> DATA.
  - DATA: accept bytes; 2-bit byte index wraps 3 -> 0. On the 4th byte of a word:
    - Next cycle: imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word.
    - words_loaded increments in the same cycle as imem_we.
    - After word N-1 is accepted -> CSUM.
  - CSUM: accept one byte.
    - Byte equals running XOR -> DONE.
    - Otherwise -> ERROR.
  - DONE: in_ready=0, done=1, cpu_reset=0. cpu_reset falls in the same cycle done rises. Stays here until reset.
  - ERROR: in_ready=0, error=1, cpu_reset stays 1. Stays here until reset.
- in_ready is 1 in HDR0, HDR1, DATA and CSUM from the first cycle after reset release; it is never dropped mid-frame. Back-to-back bytes (in_valid held high) are accepted one per cycle with no bubbles.
- Bytes presented while in_ready=0 are ignored; no state change.
- in_valid low stalls all state; there is no timeout.
- imem_addr and imem_wdata hold their last written values between strobes.
- done and error are never both 1.
- The last word's write strobe completes no later than the cycle the checksum byte is accepted. The earliest DONE is therefore 1 cycle after the checksum handshake.

Test Plan:
- Load 5-word program 0x00000013, 0x00100093, 0x00208113, 0x00310193, 0x0000006F; header 0x05 0x00; checksum 0xEE; in_valid held high.
  - Required: five imem_we pulses at addr 0..4 with exact words.
  - Required: words_loaded=5; done=1 and cpu_reset=0 one cycle after the checksum handshake; error=0.
- Same image with checksum 0xEF -> all 5 words written, then error=1, cpu_reset stays 1, done=0, in_ready=0.
- Header N=0x0101 (257 > MAX_WORDS) -> error=1 one cycle after count_hi is accepted; no imem_we pulse ever.
- N=0 then checksum 0x00 -> done=1 with zero writes. N=0 then checksum 0x01 -> error=1.
- Random in_valid gaps (~50% duty) on the 5-word image -> identical writes and final state as the first scenario.
  - Required: no byte accepted while in_ready=0; extra bytes sent after DONE are ignored.
- Assert reset_n low after 2 words of the 5-word frame, then resend the full frame.
  - Required: outputs return to reset values on the next edge; the reload ends in done=1 with words_loaded=5 and addresses restarting at 0.
